// File: rtl/alu_pkg.sv
// Shared opcodes, state encoding and byte width for the
// 8-bit ALU and its multi-byte sequencer.
package alu_pkg;

  localparam int BYTE_W = 8;

  localparam logic [2:0] OP_TSA  = 3'b000;
  localparam logic [2:0] OP_ADD  = 3'b001;
  localparam logic [2:0] OP_SUB  = 3'b010;
  localparam logic [2:0] OP_DEC  = 3'b011;
  localparam logic [2:0] OP_AND  = 3'b100;
  localparam logic [2:0] OP_OR   = 3'b101;
  localparam logic [2:0] OP_XOR  = 3'b110;
  localparam logic [2:0] OP_NOTA = 3'b111;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    DONE
  } state_t;

endpackage

// File: rtl/alu8.sv
// 8-bit ALU: arithmetic on S[2]=0 (A + {0,B,~B,FF} + Cin),
// bitwise logic on S[2]=1. Purely combinational.
module alu8
  import alu_pkg::*;
(
  input  logic [2:0] s,
  input  logic       cin,
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [7:0] g,
  output logic       v,
  output logic       c,
  output logic       n,
  output logic       z
);

  logic [7:0] bx;
  logic [8:0] sum;

  always_comb begin
    bx  = 8'h00;
    sum = 9'h000;
    g   = 8'h00;
    c   = 1'b0;
    v   = 1'b0;
    case (s)
      OP_ADD:  bx = b;
      OP_SUB:  bx = ~b;
      OP_DEC:  bx = 8'hFF;
      default: bx = 8'h00;
    endcase
    sum = {1'b0, a} + {1'b0, bx} + {8'h00, cin};
    if (!s[2]) begin
      g = sum[7:0];
      c = sum[8];
      v = (a[7] == bx[7]) && (g[7] != a[7]);
    end else begin
      case (s[1:0])
        2'b00:   g = a & b;
        2'b01:   g = a | b;
        2'b10:   g = a ^ b;
        default: g = ~a;
      endcase
    end
  end

  assign n = g[7];
  assign z = (g == 8'h00);

endmodule

// File: rtl/alu_mb_sequencer.sv
// Runs one NBYTES-wide operation through the shared 8-bit
// ALU, LSB first, and returns the wide result and flags.
module alu_mb_sequencer
  import alu_pkg::*;
#(
  parameter int NBYTES = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [2:0]               req_op,
  input  logic                     req_cin,
  input  logic [BYTE_W*NBYTES-1:0] req_a,
  input  logic [BYTE_W*NBYTES-1:0] req_b,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [BYTE_W*NBYTES-1:0] rsp_g,
  output logic                     rsp_v,
  output logic                     rsp_c,
  output logic                     rsp_n,
  output logic                     rsp_z,
  output logic [2:0]               alu_s,
  output logic                     alu_cin,
  output logic [7:0]               alu_a,
  output logic [7:0]               alu_b,
  input  logic [7:0]               alu_g,
  input  logic                     alu_v,
  input  logic                     alu_c,
  input  logic                     alu_n,
  input  logic                     alu_z
);

  localparam int W  = BYTE_W * NBYTES;
  localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IW-1:0] LAST = IW'(NBYTES - 1);

  state_t          state;
  logic [IW-1:0]   idx;
  logic [IW-1:0]   nidx;
  logic            lop;
  logic            cin_reg;
  logic            z_acc;
  logic [W-1:0]    a_reg;
  logic [W-1:0]    b_reg;
  logic [W-1:0]    g_reg;
  logic [7:0]      a_nxt;
  logic [7:0]      b_nxt;
  logic            unused_alu_n;

  assign unused_alu_n = alu_n;
  assign nidx         = idx + IW'(1);
  assign req_ready    = (state == IDLE);
  assign rsp_g        = g_reg;

  always_comb begin
    a_nxt = 8'h00;
    b_nxt = 8'h00;
    for (int i = 0; i < NBYTES; i++) begin
      if (nidx == IW'(i)) begin
        a_nxt = a_reg[BYTE_W*i +: BYTE_W];
        b_nxt = b_reg[BYTE_W*i +: BYTE_W];
      end
    end
  end

  // ALU drive is registered one byte ahead; alu_cin doubles
  // as the chained carry register for arithmetic ops.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      lop       <= 1'b0;
      cin_reg   <= 1'b0;
      z_acc     <= 1'b0;
      a_reg     <= '0;
      b_reg     <= '0;
      g_reg     <= '0;
      rsp_valid <= 1'b0;
      rsp_v     <= 1'b0;
      rsp_c     <= 1'b0;
      rsp_n     <= 1'b0;
      rsp_z     <= 1'b0;
      alu_s     <= 3'b000;
      alu_cin   <= 1'b0;
      alu_a     <= 8'h00;
      alu_b     <= 8'h00;
    end else begin
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            lop     <= req_op[2];
            cin_reg <= req_cin;
            a_reg   <= req_a;
            b_reg   <= req_b;
            idx     <= '0;
            z_acc   <= 1'b1;
            alu_s   <= req_op;
            alu_cin <= req_cin;
            alu_a   <= req_a[7:0];
            alu_b   <= req_b[7:0];
            state   <= EXEC;
          end
        end
        EXEC: begin
          g_reg[BYTE_W*idx +: BYTE_W] <= alu_g;
          z_acc <= z_acc & alu_z;
          if (idx == LAST) begin
            rsp_v     <= alu_v;
            rsp_c     <= alu_c;
            rsp_n     <= alu_g[7];
            rsp_z     <= z_acc & alu_z;
            rsp_valid <= 1'b1;
            alu_s     <= 3'b000;
            alu_cin   <= 1'b0;
            alu_a     <= 8'h00;
            alu_b     <= 8'h00;
            state     <= DONE;
          end else begin
            idx     <= nidx;
            alu_cin <= lop ? cin_reg : alu_c;
            alu_a   <= a_nxt;
            alu_b   <= b_nxt;
          end
        end
        DONE: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mb_sequencer.sv
// Bench for alu_mb_sequencer driving the 8-bit ALU,
// NBYTES=2, with a result scoreboard.
module tb_alu_mb_sequencer;
  import alu_pkg::*;

  localparam int NB = 2;
  localparam int W  = 8 * NB;

  logic         clk = 1'b0;
  logic         rst;
  logic         req_valid;
  logic         req_ready;
  logic [2:0]   req_op;
  logic         req_cin;
  logic [W-1:0] req_a;
  logic [W-1:0] req_b;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [W-1:0] rsp_g;
  logic         rsp_v, rsp_c, rsp_n, rsp_z;
  logic [2:0]   alu_s;
  logic         alu_cin;
  logic [7:0]   alu_a, alu_b, alu_g;
  logic         alu_v, alu_c, alu_n, alu_z;

  always #5 clk = ~clk;

  alu_mb_sequencer #(.NBYTES(NB)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_cin(req_cin),
    .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_g(rsp_g), .rsp_v(rsp_v), .rsp_c(rsp_c),
    .rsp_n(rsp_n), .rsp_z(rsp_z),
    .alu_s(alu_s), .alu_cin(alu_cin),
    .alu_a(alu_a), .alu_b(alu_b),
    .alu_g(alu_g), .alu_v(alu_v), .alu_c(alu_c),
    .alu_n(alu_n), .alu_z(alu_z)
  );

  alu8 u_alu (
    .s(alu_s), .cin(alu_cin), .a(alu_a), .b(alu_b),
    .g(alu_g), .v(alu_v), .c(alu_c), .n(alu_n), .z(alu_z)
  );

  typedef struct {
    logic [2:0]   op;
    logic         cin;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] g;
    logic         v, c, n, z;
  } vec_t;

  typedef struct {
    logic [W-1:0] g;
    logic         v, c, n, z;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] got,
                     input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  function automatic vec_t model(input logic [2:0] op, input logic cin,
                                 input logic [W-1:0] a, input logic [W-1:0] b);
    vec_t r;
    logic [W:0]   s;
    logic [W-1:0] bx;
    r.op = op; r.cin = cin; r.a = a; r.b = b;
    r.v = 1'b0; r.c = 1'b0;
    bx = '0; s = '0;
    case (op)
      OP_AND:  r.g = a & b;
      OP_OR:   r.g = a | b;
      OP_XOR:  r.g = a ^ b;
      OP_NOTA: r.g = ~a;
      default: begin
        bx = (op == OP_ADD) ? b : (op == OP_SUB) ? ~b :
             (op == OP_DEC) ? {W{1'b1}} : '0;
        s = {1'b0, a} + {1'b0, bx} + {{W{1'b0}}, cin};
        r.g = s[W-1:0];
        r.c = s[W];
        r.v = (a[W-1] == bx[W-1]) && (r.g[W-1] != a[W-1]);
      end
    endcase
    r.n = r.g[W-1];
    r.z = (r.g == '0);
    return r;
  endfunction

  task automatic push_exp(input vec_t v);
    exp_t e;
    e.g = v.g; e.v = v.v; e.c = v.c; e.n = v.n; e.z = v.z;
    sb.push_back(e);
  endtask

  task automatic send_req(input vec_t v, input bit keep, output bit ok);
    ok = 1'b0;
    @(negedge clk);
    req_valid = 1'b1;
    req_op = v.op; req_cin = v.cin; req_a = v.a; req_b = v.b;
    for (int i = 0; i < 30; i++) begin
      if (req_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      chk("accept_timeout", 64'd0, 64'd1);
      req_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      if (!keep) req_valid = 1'b0;
    end
  endtask

  task automatic take_rsp(input string name);
    exp_t e;
    for (int i = 0; i < 50; i++) begin
      if (rsp_valid) break;
      @(negedge clk);
    end
    if (!rsp_valid) begin
      chk({name, "_rsp_timeout"}, 64'd0, 64'd1);
      if (sb.size() > 0) void'(sb.pop_front());
    end else if (sb.size() == 0) begin
      chk({name, "_sb_empty"}, 64'd0, 64'd1);
    end else begin
      e = sb.pop_front();
      chk({name, "_g"}, 64'(rsp_g), 64'(e.g));
      chk({name, "_v"}, 64'(rsp_v), 64'(e.v));
      chk({name, "_c"}, 64'(rsp_c), 64'(e.c));
      chk({name, "_n"}, 64'(rsp_n), 64'(e.n));
      chk({name, "_z"}, 64'(rsp_z), 64'(e.z));
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
  endtask

  task automatic do_op(input vec_t v, input string name,
                       output logic [NB-1:0] cins);
    bit ok;
    logic [W-1:0] ta;
    logic [W-1:0] tb;
    cins = '0;
    ta = v.a;
    tb = v.b;
    push_exp(v);
    send_req(v, 1'b0, ok);
    if (ok) begin
      for (int i = 0; i < NB; i++) begin
        @(negedge clk);
        cins[i] = alu_cin;
        chk($sformatf("%s_alu_s%0d", name, i), 64'(alu_s), 64'(v.op));
        chk($sformatf("%s_alu_a%0d", name, i), 64'(alu_a), 64'(ta[8*i +: 8]));
        chk($sformatf("%s_alu_b%0d", name, i), 64'(alu_b), 64'(tb[8*i +: 8]));
      end
      @(negedge clk);
      chk({name, "_latency"}, 64'(rsp_valid), 64'd1);
    end
    take_rsp(name);
  endtask

  vec_t tbl[11];
  logic [NB-1:0] cins;
  vec_t v;
  bit ok;
  int acc_t[$];
  int nrsp;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    tbl[0]  = '{OP_ADD, 1'b0, 16'h00FF, 16'h0001, 16'h0100, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{OP_SUB, 1'b1, 16'h1234, 16'h1234, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[2]  = '{OP_SUB, 1'b1, 16'h1200, 16'h0200, 16'h1000, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[3]  = '{OP_ADD, 1'b0, 16'h7FFF, 16'h0001, 16'h8000, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[4]  = '{OP_AND, 1'b1, 16'hF0F0, 16'hFF00, 16'hF000, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[5]  = '{OP_OR,  1'b0, 16'h0F00, 16'h00F0, 16'h0FF0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[6]  = '{OP_DEC, 1'b0, 16'h0000, 16'h0000, 16'hFFFF, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[7]  = '{OP_TSA, 1'b1, 16'hFFFF, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[8]  = '{OP_SUB, 1'b1, 16'h0000, 16'h0001, 16'hFFFF, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[9]  = '{OP_SUB, 1'b1, 16'h8000, 16'h0001, 16'h7FFF, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[10] = '{OP_ADD, 1'b1, 16'hFFFF, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1};

    rst = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0;
    req_op = 3'b000; req_cin = 1'b0; req_a = '0; req_b = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", 64'(req_ready), 64'd1);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp_g", 64'(rsp_g), 64'd0);
    chk("rst_flags", 64'({rsp_v, rsp_c, rsp_n, rsp_z}), 64'd0);
    chk("rst_alu", 64'({alu_s, alu_cin, alu_a, alu_b}), 64'd0);
    rst = 1'b0;

    // rsp_ready while idle must not disturb anything
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    chk("idle_rsp_ready_rr", 64'(req_ready), 64'd1);
    chk("idle_rsp_ready_rv", 64'(rsp_valid), 64'd0);

    for (int i = 0; i < 11; i++) begin
      do_op(tbl[i], $sformatf("vec%0d", i), cins);
      if (i == 0) chk("add_carry_chain_cin", 64'(cins), 64'b10);
      if (i == 4) chk("logic_cin_no_chain", 64'(cins), 64'b11);
      if (i == 8) chk("sub_borrow_cin", 64'(cins), 64'b01);
    end

    for (int i = 0; i < 8; i++) begin
      v = model(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                16'($urandom), 16'($urandom));
      do_op(v, $sformatf("rnd%0d", i), cins);
    end

    // response held off for five cycles
    v = model(OP_ADD, 1'b0, 16'h1234, 16'h1111);
    push_exp(v);
    send_req(v, 1'b0, ok);
    for (int i = 0; i < 20; i++) begin
      if (rsp_valid) break;
      @(negedge clk);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("hold_valid%0d", i), 64'(rsp_valid), 64'd1);
      chk($sformatf("hold_g%0d", i), 64'(rsp_g), 64'h2345);
      chk($sformatf("hold_rr%0d", i), 64'(req_ready), 64'd0);
    end
    take_rsp("hold");

    // second request while busy is not taken
    v = model(OP_ADD, 1'b0, 16'h0001, 16'h0002);
    push_exp(v);
    send_req(v, 1'b1, ok);
    @(negedge clk);
    req_a = 16'hAAAA; req_b = 16'h5555; req_op = OP_OR;
    for (int i = 0; i < NB; i++) begin
      chk($sformatf("busy_rr%0d", i), 64'(req_ready), 64'd0);
      @(negedge clk);
    end
    req_valid = 1'b0;
    take_rsp("busy");
    @(negedge clk);
    chk("busy_back_idle", 64'(req_ready), 64'd1);

    // reset in the middle of byte 0
    v = model(OP_SUB, 1'b1, 16'h5678, 16'h1234);
    send_req(v, 1'b0, ok);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("midrst_req_ready", 64'(req_ready), 64'd1);
    chk("midrst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("midrst_rsp_g", 64'(rsp_g), 64'd0);
    chk("midrst_alu", 64'({alu_s, alu_cin, alu_a, alu_b}), 64'd0);
    do_op(tbl[3], "after_rst", cins);

    // back-to-back issue with rsp_ready held high
    nrsp = 0;
    rsp_ready = 1'b1;
    req_op = OP_ADD; req_cin = 1'b0; req_a = 16'h0001; req_b = 16'h0001;
    @(negedge clk);
    req_valid = 1'b1;
    for (int cyc = 0; cyc < 14; cyc++) begin
      if (cyc > 0) @(negedge clk);
      if (req_valid && req_ready) acc_t.push_back(cyc);
      if (rsp_valid) begin
        nrsp++;
        chk($sformatf("b2b_g%0d", nrsp), 64'(rsp_g), 64'h0002);
      end
    end
    req_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (req_ready) break;
    end
    rsp_ready = 1'b0;
    chk("b2b_drain", 64'(req_ready), 64'd1);
    chk("b2b_accepts", 64'(acc_t.size()), 64'd4);
    chk("b2b_responses", 64'(nrsp), 64'd3);
    for (int i = 1; i < acc_t.size(); i++)
      chk($sformatf("b2b_gap%0d", i), 64'(acc_t[i] - acc_t[i-1]), 64'd4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
